// File: rtl/lat_req_gen_pkg.sv
// rtl/lat_req_gen_pkg.sv - shared types and constants for lat_req_gen
// Contents: FSM state enum, err_flags bit indices, default parameter values.
package lat_req_gen_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } lrg_state_t;

  localparam int ERR_UNEXP_TLAST = 0;
  localparam int ERR_BEAT_CNT    = 1;

  localparam int LRG_ADDR_W    = 48;
  localparam int LRG_LEN_W     = 28;
  localparam int LRG_DATA_W    = 512;
  localparam int LRG_MAX_OUTST = 16;

endpackage

// File: rtl/lrg_outst_ctr.sv
// rtl/lrg_outst_ctr.sv - outstanding request counter for lat_req_gen
// Ports:
//   aclk, aresetn      clock, synchronous active-low reset
//   i_inc              request handshake
//   i_dec              response tlast handshake
//   o_full             count has reached MAX_OUTST
//   o_underflow_pulse  i_dec seen with nothing outstanding (count held at 0)
module lrg_outst_ctr
  import lat_req_gen_pkg::*;
#(
  parameter int MAX_OUTST = LRG_MAX_OUTST
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_underflow_pulse
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_zero;

  assign w_zero            = (r_cnt == '0);
  assign o_full            = (r_cnt == CNT_W'(MAX_OUTST));
  // A tlast that coincides with a new request is matched by it, so only a
  // lone decrement at zero is an underflow.
  assign o_underflow_pulse = i_dec && !i_inc && w_zero;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !w_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/lat_req_gen.sv
// rtl/lat_req_gen.sv - read-latency request generator and response sink
// Optional build macro: LAT_REQ_GEN_BEAT_CHK_EN enables the per-response beat
// counter driving err_flags[1]; without it err_flags[1] is 0 and sink_tdata
// is ignored.
// Ports:
//   aclk, aresetn               clock, synchronous active-low reset
//   start                       launch pulse, taken in IDLE or DONE only
//   cfg_num_req/base_addr/stride/len/gap   run configuration, latched on start
//   rd_req_valid/ready/vaddr/len           read-request channel
//   sink_tvalid/tready/tlast/tdata         returned data stream
//   busy, done                  run status
//   reqs_issued, resps_done     request / tlast handshakes since launch
//   err_flags                   [0] unexpected tlast, [1] beat-count mismatch
module lat_req_gen
  import lat_req_gen_pkg::*;
#(
  parameter int ADDR_W    = LRG_ADDR_W,
  parameter int LEN_W     = LRG_LEN_W,
  parameter int DATA_W    = LRG_DATA_W,
  parameter int MAX_OUTST = LRG_MAX_OUTST
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [31:0]       cfg_num_req,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [15:0]       cfg_gap,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_vaddr,
  output logic [LEN_W-1:0]  rd_req_len,
  input  logic              sink_tvalid,
  output logic              sink_tready,
  input  logic              sink_tlast,
  input  logic [DATA_W-1:0] sink_tdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       reqs_issued,
  output logic [31:0]       resps_done,
  output logic [1:0]        err_flags
);

  lrg_state_t        r_state, w_state_nxt;
  logic [31:0]       r_num, r_reqs_issued, r_resps_done;
  logic [ADDR_W-1:0] r_vaddr, r_stride;
  logic [LEN_W-1:0]  r_len;
  logic [15:0]       r_gap, r_gap_cnt;
  logic              r_err_unexp, w_err_beat;
  logic              w_full, w_underflow;
  logic              w_req_valid, w_req_hs, w_beat_hs, w_tlast_hs;
  logic              w_start_acc, w_last_req;
  logic              w_unused_tdata;

  // Responses are never back-pressured; ready drops only while in reset.
  assign sink_tready    = aresetn;
  assign w_unused_tdata = ^sink_tdata;

  // Only a handshake can raise the count, so valid cannot fall while pending.
  assign w_req_valid = (r_state == ISSUE) && !w_full;
  assign w_req_hs    = w_req_valid && rd_req_ready;
  assign w_beat_hs   = sink_tvalid && sink_tready;
  assign w_tlast_hs  = w_beat_hs && sink_tlast;
  assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last_req  = ((r_reqs_issued + 32'd1) == r_num);

  assign rd_req_valid = w_req_valid;
  assign rd_req_vaddr = r_vaddr;
  assign rd_req_len   = r_len;
  assign busy         = (r_state == ISSUE) || (r_state == GAP) || (r_state == DRAIN);
  assign done         = (r_state == DONE);
  assign reqs_issued  = r_reqs_issued;
  assign resps_done   = r_resps_done;
  assign err_flags[ERR_UNEXP_TLAST] = r_err_unexp;
  assign err_flags[ERR_BEAT_CNT]    = w_err_beat;

  lrg_outst_ctr #(
    .MAX_OUTST(MAX_OUTST)
  ) u_outst (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .i_inc            (w_req_hs),
    .i_dec            (w_tlast_hs),
    .o_full           (w_full),
    .o_underflow_pulse(w_underflow)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = (cfg_num_req == 32'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (w_req_hs) begin
          if (w_last_req) begin
            w_state_nxt = DRAIN;
          end else if (r_gap != 16'd0) begin
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt <= 16'd1) begin
          w_state_nxt = ISSUE;
        end
      end
      DRAIN: begin
        if (r_resps_done == r_num) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_num         <= '0;
      r_vaddr       <= '0;
      r_stride      <= '0;
      r_len         <= '0;
      r_gap         <= '0;
      r_gap_cnt     <= '0;
      r_reqs_issued <= '0;
      r_resps_done  <= '0;
      r_err_unexp   <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_num         <= cfg_num_req;
        r_vaddr       <= cfg_base_addr;
        r_stride      <= cfg_stride;
        r_len         <= cfg_len;
        r_gap         <= cfg_gap;
        r_reqs_issued <= '0;
        r_resps_done  <= '0;
        r_err_unexp   <= 1'b0;
      end else begin
        if (w_req_hs) begin
          r_reqs_issued <= r_reqs_issued + 32'd1;
          r_vaddr       <= r_vaddr + r_stride;
          r_gap_cnt     <= r_gap;
        end else if (r_state == GAP) begin
          r_gap_cnt <= r_gap_cnt - 16'd1;
        end
        if (w_tlast_hs && !w_underflow) begin
          r_resps_done <= r_resps_done + 32'd1;
        end
      end
      // A stray tlast must stay visible even in the cycle of a relaunch.
      if (w_underflow) begin
        r_err_unexp <= 1'b1;
      end
    end
  end

`ifdef LAT_REQ_GEN_BEAT_CHK_EN
  localparam int BEAT_SH = $clog2(DATA_W / 8);

  logic [LEN_W-1:0] r_beat_cnt, w_beat_num, w_exp_beats;
  logic             r_err_beat;

  assign w_beat_num  = r_beat_cnt + 1'b1;
  assign w_exp_beats = r_len >> BEAT_SH;
  assign w_err_beat  = r_err_beat;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_beat_cnt <= '0;
      r_err_beat <= 1'b0;
    end else if (w_start_acc) begin
      r_beat_cnt <= '0;
      r_err_beat <= 1'b0;
    end else if (w_beat_hs) begin
      if (sink_tlast) begin
        r_beat_cnt <= '0;
        if (w_beat_num != w_exp_beats) begin
          r_err_beat <= 1'b1;
        end
      end else if (w_beat_num == w_exp_beats) begin
        // Full length without tlast: flag it and treat the next beat as a new response.
        r_beat_cnt <= '0;
        r_err_beat <= 1'b1;
      end else begin
        r_beat_cnt <= w_beat_num;
      end
    end
  end
`else
  assign w_err_beat = 1'b0;
`endif

endmodule

// File: tb/tb_lat_req_gen.sv
// tb/tb_lat_req_gen.sv - self-checking bench for lat_req_gen
module tb_lat_req_gen;

  localparam int AW = 16;
  localparam int LW = 28;
  localparam int DW = 512;
  localparam int MO = 4;
  localparam int BYTES_PER_BEAT = DW / 8;
`ifdef LAT_REQ_GEN_BEAT_CHK_EN
  localparam bit BEAT_CHK = 1'b1;
`else
  localparam bit BEAT_CHK = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start;
  logic [31:0]   cfg_num_req;
  logic [AW-1:0] cfg_base_addr, cfg_stride;
  logic [LW-1:0] cfg_len;
  logic [15:0]   cfg_gap;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_vaddr;
  logic [LW-1:0] rd_req_len;
  logic          sink_tvalid, sink_tready, sink_tlast;
  logic [DW-1:0] sink_tdata;
  logic          busy, done;
  logic [31:0]   reqs_issued, resps_done;
  logic [1:0]    err_flags;

  always #5 aclk = ~aclk;

  lat_req_gen #(
    .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .MAX_OUTST(MO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .cfg_num_req(cfg_num_req), .cfg_base_addr(cfg_base_addr),
    .cfg_stride(cfg_stride), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_vaddr(rd_req_vaddr), .rd_req_len(rd_req_len),
    .sink_tvalid(sink_tvalid), .sink_tready(sink_tready),
    .sink_tlast(sink_tlast), .sink_tdata(sink_tdata),
    .busy(busy), .done(done), .reqs_issued(reqs_issued),
    .resps_done(resps_done), .err_flags(err_flags)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned   cyc = 0;
  bit            m_active, m_done, m_err0, m_err1;
  int unsigned   m_num, m_issued, m_resps, m_next_ok, m_gap, m_beats;
  int            m_outst;
  logic [AW-1:0] m_base, m_stride;
  logic [LW-1:0] m_len;
  int unsigned   due_q[$];
  int unsigned   hs_cyc_q[$];
  logic [AW-1:0] hs_addr_q[$];
  bit            man_q[$];
  int            resp_mode  = 0;  // 0 none, 1 random, 2 fixed +10, 3 manual queue
  int            ready_mode = 0;  // 0 high, 1 random, 2 low

  function automatic bit model_valid();
    return m_active && !m_done && (m_issued < m_num) && (cyc >= m_next_ok) && (m_outst < MO);
  endfunction

  function automatic logic [AW-1:0] model_vaddr();
    logic [AW-1:0] k;
    k = AW'(m_issued);
    return m_base + k * m_stride;
  endfunction

  function automatic int unsigned model_exp_beats();
    return int'(m_len) / BYTES_PER_BEAT;
  endfunction

  initial begin : model
    bit mv, hs, tl, sa, dn;
    m_active = 0; m_done = 0; m_err0 = 0; m_err1 = 0; m_num = 0; m_issued = 0;
    m_resps = 0; m_next_ok = 0; m_gap = 0; m_beats = 0; m_outst = 0;
    m_base = '0; m_stride = '0; m_len = '0;
    forever begin
      @(posedge aclk);
      if (!aresetn) begin
        m_active = 0; m_done = 0; m_err0 = 0; m_err1 = 0; m_num = 0; m_issued = 0;
        m_resps = 0; m_next_ok = 0; m_gap = 0; m_beats = 0; m_outst = 0;
        m_base = '0; m_stride = '0; m_len = '0;
        due_q.delete();
      end else begin
        mv = model_valid();
        hs = mv && rd_req_ready;
        tl = sink_tvalid && sink_tlast;
        sa = start && (!m_active || m_done);
        dn = m_active && !m_done && (m_issued == m_num) && (m_resps == m_num);
        if (sa) begin
          m_num = cfg_num_req; m_base = cfg_base_addr; m_stride = cfg_stride;
          m_len = cfg_len; m_gap = cfg_gap; m_issued = 0; m_resps = 0;
          m_err0 = 0; m_err1 = 0; m_beats = 0; m_active = 1;
          m_done = (cfg_num_req == 0);
          m_next_ok = cyc + 1;
        end else begin
          if (hs) begin
            m_issued++;
            m_next_ok = cyc + 1 + m_gap;
            if (resp_mode == 2) due_q.push_back(cyc + 10);
          end
          if (dn) m_done = 1;
        end
        if (tl) begin
          if (!hs && m_outst == 0) m_err0 = 1;
          else begin
            if (!sa) m_resps++;
            if (!hs) m_outst--;
          end
        end else if (hs) begin
          m_outst++;
        end
        if (BEAT_CHK && !sa && sink_tvalid) begin
          m_beats++;
          if (sink_tlast) begin
            if (m_beats != model_exp_beats()) m_err1 = 1;
            m_beats = 0;
          end else if (m_beats == model_exp_beats()) begin
            m_err1 = 1;
            m_beats = 0;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge aclk);
      if (chk_en) begin
        chk("valid",       64'(rd_req_valid), 64'(model_valid()));
        chk("vaddr",       64'(rd_req_vaddr), 64'(model_vaddr()));
        chk("len",         64'(rd_req_len),   64'(m_len));
        chk("busy",        64'(busy),         64'(m_active && !m_done));
        chk("done",        64'(done),         64'(m_done));
        chk("reqs_issued", 64'(reqs_issued),  64'(m_issued));
        chk("resps_done",  64'(resps_done),   64'(m_resps));
        chk("err_flags",   64'(err_flags),    64'({m_err1, m_err0}));
        chk("sink_tready", 64'(sink_tready),  64'(aresetn));
        if (rd_req_valid && rd_req_ready) begin
          hs_cyc_q.push_back(cyc);
          hs_addr_q.push_back(rd_req_vaddr);
        end
      end
    end
  end

  // ---------------- ready / response driver ----------------
  initial begin : driver
    int unsigned beats_left;
    beats_left = 0;
    rd_req_ready = 1'b1; sink_tvalid = 1'b0; sink_tlast = 1'b0; sink_tdata = '0;
    forever begin
      @(posedge aclk);
      #2;
      case (ready_mode)
        1:       rd_req_ready = ($urandom % 4) != 0;
        2:       rd_req_ready = 1'b0;
        default: rd_req_ready = 1'b1;
      endcase
      sink_tvalid = 1'b0;
      sink_tlast  = 1'b0;
      sink_tdata  = {16{$urandom}};
      case (resp_mode)
        1: begin
          if (beats_left == 0 && m_outst > 0 && ($urandom % 3) == 0)
            beats_left = (model_exp_beats() == 0) ? 1 : model_exp_beats();
          if (beats_left > 0 && ($urandom % 4) != 0) begin
            sink_tvalid = 1'b1;
            sink_tlast  = (beats_left == 1);
            beats_left--;
          end
        end
        2: begin
          beats_left = 0;
          if (due_q.size() > 0 && due_q[0] <= cyc) begin
            sink_tvalid = 1'b1;
            sink_tlast  = 1'b1;
            void'(due_q.pop_front());
          end
        end
        3: begin
          beats_left = 0;
          if (man_q.size() > 0) begin
            sink_tvalid = 1'b1;
            sink_tlast  = man_q.pop_front();
          end
        end
        default: beats_left = 0;
      endcase
    end
  end

  // ---------------- main stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic launch(input int unsigned num, input logic [AW-1:0] base,
                        input logic [AW-1:0] stride, input int unsigned len,
                        input int unsigned gap);
    cfg_num_req = num; cfg_base_addr = base; cfg_stride = stride;
    cfg_len = LW'(len); cfg_gap = 16'(gap);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cfg_num_req = $urandom; cfg_base_addr = AW'($urandom); cfg_stride = AW'($urandom);
    cfg_len = LW'($urandom); cfg_gap = 16'($urandom);
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    int k;
    k = 0;
    while (!done && k < max_cyc) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: done not reached within %0d cycles", nm, max_cyc);
    end
  endtask

  initial begin : main
    aresetn = 1'b0; start = 1'b0; cfg_num_req = '0; cfg_base_addr = '0;
    cfg_stride = '0; cfg_len = '0; cfg_gap = '0;
    tick(3);
    chk_en = 1'b1;
    chk("rst_valid",  64'(rd_req_valid), 64'd0);
    chk("rst_tready", 64'(sink_tready),  64'd0);
    chk("rst_vaddr",  64'(rd_req_vaddr), 64'd0);
    chk("rst_done",   64'(done),         64'd0);
    aresetn = 1'b1;
    tick(1);
    chk("tready_after_reset", 64'(sink_tready), 64'd1);

    // unsolicited tlast in IDLE, then an empty run
    resp_mode = 3;
    man_q.push_back(1'b1);
    tick(3);
    chk("idle_tlast_err",   64'(err_flags),  64'd1);
    chk("idle_tlast_resps", 64'(resps_done), 64'd0);
    launch(0, 16'h0, 16'h0, 64, 0);
    chk("num0_done", 64'(done),      64'd1);
    chk("num0_err",  64'(err_flags), 64'd0);

    // four back-to-back requests, responses 10 cycles later
    hs_cyc_q.delete(); hs_addr_q.delete();
    resp_mode = 2;
    launch(4, 16'h1000, 16'h0040, 64, 0);
    wait_done("t1_done", 200);
    chk("t1_reqs",  64'(reqs_issued), 64'd4);
    chk("t1_resps", 64'(resps_done),  64'd4);
    chk("t1_err",   64'(err_flags),   64'd0);
    chk("t1_hs_count", 64'(hs_addr_q.size()), 64'd4);
    if (hs_addr_q.size() == 4) begin
      chk("t1_addr0", 64'(hs_addr_q[0]), 64'h1000);
      chk("t1_addr1", 64'(hs_addr_q[1]), 64'h1040);
      chk("t1_addr2", 64'(hs_addr_q[2]), 64'h1080);
      chk("t1_addr3", 64'(hs_addr_q[3]), 64'h10C0);
      for (int i = 1; i < 4; i++)
        chk("t1_hs_spacing", 64'(hs_cyc_q[i] - hs_cyc_q[i-1]), 64'd1);
    end

    // gap of 5 -> handshakes 6 cycles apart
    hs_cyc_q.delete(); hs_addr_q.delete();
    launch(3, 16'h2000, 16'h0100, 64, 5);
    wait_done("t2_done", 200);
    chk("t2_hs_count", 64'(hs_cyc_q.size()), 64'd3);
    if (hs_cyc_q.size() == 3) begin
      chk("t2_spacing0", 64'(hs_cyc_q[1] - hs_cyc_q[0]), 64'd6);
      chk("t2_spacing1", 64'(hs_cyc_q[2] - hs_cyc_q[1]), 64'd6);
    end

    // outstanding limit with responses withheld
    resp_mode = 0;
    launch(6, 16'h3000, 16'h0010, 64, 0);
    tick(15);
    chk("t3_reqs_at_limit",  64'(reqs_issued),  64'(MO));
    chk("t3_valid_at_limit", 64'(rd_req_valid), 64'd0);
    resp_mode = 3;
    man_q.push_back(1'b1);
    tick(10);
    chk("t3_reqs_after_one", 64'(reqs_issued),  64'(MO + 1));
    chk("t3_valid_after_one", 64'(rd_req_valid), 64'd0);
    resp_mode = 1;
    wait_done("t3_done", 500);

    // ready held low: request held stable, stray start ignored
    ready_mode = 2;
    launch(3, 16'h4000, 16'h0020, 128, 0);
    tick(7);
    cfg_num_req = 32'd99;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t4_valid_held", 64'(rd_req_valid), 64'd1);
    chk("t4_vaddr_held", 64'(rd_req_vaddr), 64'h4000);
    chk("t4_len_held",   64'(rd_req_len),   64'd128);
    chk("t4_no_count",   64'(reqs_issued),  64'd0);
    ready_mode = 0;
    wait_done("t4_done", 500);
    chk("t4_reqs", 64'(reqs_issued), 64'd3);

    // beat-count check: short response then a correct one
    resp_mode = 3;
    launch(2, 16'h5000, 16'h0080, 128, 0);
    tick(4);
    man_q.push_back(1'b1);
    tick(3);
    chk("t5_short_resp", 64'(err_flags[1]), 64'(BEAT_CHK));
    man_q.push_back(1'b0);
    man_q.push_back(1'b1);
    tick(4);
    chk("t5_good_resp",  64'(err_flags[1]), 64'(BEAT_CHK));
    chk("t5_resps",      64'(resps_done),   64'd2);
    wait_done("t5_done", 50);

    // randomized runs
    resp_mode = 1;
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      launch($urandom_range(1, 12), AW'($urandom), AW'($urandom),
             BYTES_PER_BEAT * $urandom_range(1, 3), $urandom_range(0, 3));
      wait_done("rand_done", 3000);
    end

    // mid-run reset, then a stale response
    resp_mode = 0;
    ready_mode = 0;
    launch(8, 16'hF000, 16'h1000, 64, 1);
    tick(6);
    aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(1);
    chk("rst_mid_reqs",  64'(reqs_issued), 64'd0);
    chk("rst_mid_busy",  64'(busy),        64'd0);
    resp_mode = 3;
    man_q.push_back(1'b1);
    tick(3);
    chk("stale_tlast_err", 64'(err_flags[0]), 64'd1);
    resp_mode = 1;
    launch(2, 16'hFFC0, 16'h0040, 64, 0);
    wait_done("post_reset_done", 500);
    chk("post_reset_err", 64'(err_flags), 64'd0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
